// File: rtl/hevc_interp_pkg.sv
// Shared types and geometry for the HEVC interpolation datapath.
package hevc_interp_pkg;

    localparam int PIX_W   = 8;
    localparam int BLK_DIM = 15;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

endpackage

// File: rtl/ref_row_bank.sv
// One reference-block bank: BLK_DIM row registers with a single-sample
// write port and a whole-row read port. Storage is data-only, so there is no reset.
module ref_row_bank #(
    parameter int PIX_W   = 8,
    parameter int BLK_DIM = 15,
    parameter int RW      = $clog2(BLK_DIM)
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [RW-1:0]            wr_row,
    input  logic [RW-1:0]            wr_col,
    input  logic [PIX_W-1:0]         wr_data,
    input  logic [RW-1:0]            rd_row,
    output logic [PIX_W*BLK_DIM-1:0] rd_data
);

    logic [PIX_W*BLK_DIM-1:0] rows [BLK_DIM];

    // Column 0 sits in the least-significant sample slot of each row.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            rows[wr_row][PIX_W*wr_col +: PIX_W] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (int'(rd_row) < BLK_DIM) begin
            rd_data = rows[rd_row];
        end
    end

endmodule

// File: rtl/ref_block_loader.sv
// Double-buffered reference-block loader: fills one bank from a raster sample
// stream while the other bank is served row by row to the interpolator.
module ref_block_loader #(
    parameter int PIX_W   = hevc_interp_pkg::PIX_W,
    parameter int BLK_DIM = hevc_interp_pkg::BLK_DIM
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PIX_W-1:0]         pix_in,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic [7:0]               next_row,
    output logic [PIX_W*BLK_DIM-1:0] in_row,
    output logic                     blk_valid,
    input  logic                     blk_done,
    output logic                     rd_bank
);

    import hevc_interp_pkg::*;

    localparam int            RW       = $clog2(BLK_DIM);
    localparam int            ROW_W    = PIX_W * BLK_DIM;
    localparam logic [RW-1:0] LAST_IDX = RW'(BLK_DIM - 1);

    bank_state_t     bank_st     [2];
    bank_state_t     bank_st_nxt [2];
    logic            wr_bank;
    logic            wr_bank_nxt;
    logic            rd_bank_nxt;
    logic [RW-1:0]   col_q;
    logic [RW-1:0]   row_q;
    logic [RW-1:0]   col_nxt;
    logic [RW-1:0]   row_nxt;
    logic            xfer;
    logic            last_xfer;
    logic            release_blk;
    logic [ROW_W-1:0] bank_row [2];

    // Ready depends only on registered bank state, never on pix_valid.
    assign pix_ready   = (bank_st[wr_bank] != FULL);
    assign blk_valid   = (bank_st[rd_bank] == FULL);
    assign xfer        = pix_valid && pix_ready;
    assign last_xfer   = xfer && (row_q == LAST_IDX) && (col_q == LAST_IDX);
    assign release_blk = blk_done && blk_valid;

    // A release always targets a FULL bank and a write never does, so both
    // updates can land in the same cycle without touching the same entry.
    always_comb begin
        bank_st_nxt[0] = bank_st[0];
        bank_st_nxt[1] = bank_st[1];
        wr_bank_nxt    = wr_bank;
        rd_bank_nxt    = rd_bank;
        col_nxt        = col_q;
        row_nxt        = row_q;
        if (xfer) begin
            if (last_xfer) begin
                bank_st_nxt[wr_bank] = FULL;
                wr_bank_nxt          = ~wr_bank;
                col_nxt              = '0;
                row_nxt              = '0;
            end else begin
                bank_st_nxt[wr_bank] = FILLING;
                if (col_q == LAST_IDX) begin
                    col_nxt = '0;
                    row_nxt = row_q + 1'b1;
                end else begin
                    col_nxt = col_q + 1'b1;
                end
            end
        end
        if (release_blk) begin
            bank_st_nxt[rd_bank] = EMPTY;
            rd_bank_nxt          = ~rd_bank;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
        end else begin
            bank_st[0] <= bank_st_nxt[0];
            bank_st[1] <= bank_st_nxt[1];
            wr_bank    <= wr_bank_nxt;
            rd_bank    <= rd_bank_nxt;
            col_q      <= col_nxt;
            row_q      <= row_nxt;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        ref_row_bank #(
            .PIX_W   (PIX_W),
            .BLK_DIM (BLK_DIM),
            .RW      (RW)
        ) u_bank (
            .clk     (clk),
            .wr_en   (xfer && (wr_bank == 1'(b))),
            .wr_row  (row_q),
            .wr_col  (col_q),
            .wr_data (pix_in),
            .rd_row  (next_row[RW-1:0]),
            .rd_data (bank_row[b])
        );
    end

    always_comb begin
        in_row = '0;
        if (blk_valid && (int'(next_row) < BLK_DIM)) begin
            in_row = bank_row[rd_bank];
        end
    end

endmodule

// File: tb/tb_ref_block_loader.sv
// Directed bench for ref_block_loader: fills, stalls, releases, coincident
// release/fill, out-of-range rows and reset mid-fill.
module tb_ref_block_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   pix_in;
    logic         pix_valid;
    logic         pix_ready;
    logic [7:0]   next_row;
    logic [119:0] in_row;
    logic         blk_valid;
    logic         blk_done;
    logic         rd_bank;

    int n_pass  = 0;
    int n_total = 0;
    int bv_low  = 0;

    ref_block_loader #(.PIX_W(8), .BLK_DIM(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .next_row  (next_row),
        .in_row    (in_row),
        .blk_valid (blk_valid),
        .blk_done  (blk_done),
        .rd_bank   (rd_bank)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [119:0] obs, input logic [119:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_row(input string tag, input logic [7:0] r, input logic [119:0] exp);
        next_row = r;
        #1;
        check(tag, in_row, exp);
    endtask

    // Streams 225 samples base, base+1, ... (mod 256); optionally pulses
    // blk_done together with the final sample.
    task automatic fill_block(input logic [7:0] base, input bit done_at_last, input bit chk_rise);
        for (int i = 0; i < 225; i++) begin
            pix_in    = base + 8'(i);
            pix_valid = 1'b1;
            blk_done  = done_at_last && (i == 224);
            #1;
            if (!blk_valid) bv_low++;
            if (chk_rise && i == 224) check("blk_valid_before_last", 120'(blk_valid), 120'(1'b0));
            tick();
        end
        pix_valid = 1'b0;
        blk_done  = 1'b0;
    endtask

    task automatic pulse_done();
        blk_done = 1'b1;
        tick();
        blk_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pix_in = '0; pix_valid = 1'b0; next_row = '0; blk_done = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_ready", 120'(pix_ready), 120'(1'b1));
        check("rst_blk_valid", 120'(blk_valid), 120'(1'b0));
        check("rst_rd_bank", 120'(rd_bank), 120'(1'b0));
        chk_row("rst_in_row", 8'd0, 120'h0);

        // Block A into bank 0: samples 0x00..0xE0
        fill_block(8'h00, 1'b0, 1'b1);
        check("A_blk_valid", 120'(blk_valid), 120'(1'b1));
        check("A_rd_bank", 120'(rd_bank), 120'(1'b0));
        check("A_ready", 120'(pix_ready), 120'(1'b1));
        chk_row("A_row1", 8'd1, 120'h1d1c1b1a191817161514131211100f);
        chk_row("A_row0", 8'd0, 120'h0e0d0c0b0a09080706050403020100);
        chk_row("A_row14", 8'd14, 120'he0dfdedddcdbdad9d8d7d6d5d4d3d2);
        chk_row("A_row15", 8'd15, 120'h0);
        chk_row("A_rowFF", 8'hFF, 120'h0);

        // Block B into bank 1, then the loader must stall
        fill_block(8'h40, 1'b0, 1'b0);
        check("B_ready_stalled", 120'(pix_ready), 120'(1'b0));
        check("B_rd_bank", 120'(rd_bank), 120'(1'b0));
        pix_in = 8'hAA; pix_valid = 1'b1;
        repeat (3) tick();
        check("stall_ready", 120'(pix_ready), 120'(1'b0));
        check("stall_blk_valid", 120'(blk_valid), 120'(1'b1));
        chk_row("stall_A_row0", 8'd0, 120'h0e0d0c0b0a09080706050403020100);

        // Release while stalled: bank 1 served, ready returns next cycle
        pulse_done();
        pix_valid = 1'b0;
        check("rel1_rd_bank", 120'(rd_bank), 120'(1'b1));
        check("rel1_blk_valid", 120'(blk_valid), 120'(1'b1));
        check("rel1_ready", 120'(pix_ready), 120'(1'b1));
        chk_row("B_row0", 8'd0, 120'h4e4d4c4b4a49484746454443424140);

        // Block C into bank 0 (no stray 0xAA may have slipped in)
        fill_block(8'h80, 1'b0, 1'b0);
        check("C_ready_stalled", 120'(pix_ready), 120'(1'b0));
        check("C_rd_bank", 120'(rd_bank), 120'(1'b1));
        pulse_done();
        check("rel2_rd_bank", 120'(rd_bank), 120'(1'b0));
        check("rel2_ready", 120'(pix_ready), 120'(1'b1));
        chk_row("C_row0", 8'd0, 120'h8e8d8c8b8a89888786858483828180);

        // Block D into bank 1 with blk_done on its final sample
        bv_low = 0;
        fill_block(8'hC0, 1'b1, 1'b0);
        check("D_bv_low_count", 120'(bv_low), 120'(0));
        check("D_blk_valid", 120'(blk_valid), 120'(1'b1));
        check("D_rd_bank", 120'(rd_bank), 120'(1'b1));
        check("D_ready", 120'(pix_ready), 120'(1'b1));
        chk_row("D_row0", 8'd0, 120'hcecdcccbcac9c8c7c6c5c4c3c2c1c0);
        tick();
        check("D_blk_valid_hold", 120'(blk_valid), 120'(1'b1));

        // Reset mid-serve
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_blk_valid", 120'(blk_valid), 120'(1'b0));
        check("rst2_rd_bank", 120'(rd_bank), 120'(1'b0));
        check("rst2_ready", 120'(pix_ready), 120'(1'b1));
        chk_row("rst2_in_row", 8'd0, 120'h0);

        // 100 samples, then reset discards the partial block
        for (int i = 0; i < 100; i++) begin
            pix_in = 8'h10 + 8'(i); pix_valid = 1'b1;
            tick();
        end
        pix_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulse_done();
        check("idle_done_rd_bank", 120'(rd_bank), 120'(1'b0));
        check("idle_done_blk_valid", 120'(blk_valid), 120'(1'b0));

        // Clean block E into bank 0
        fill_block(8'h20, 1'b0, 1'b0);
        check("E_blk_valid", 120'(blk_valid), 120'(1'b1));
        check("E_rd_bank", 120'(rd_bank), 120'(1'b0));
        chk_row("E_row0", 8'd0, 120'h2e2d2c2b2a29282726252423222120);
        chk_row("E_row14", 8'd14, 120'h00fffefdfcfbfaf9f8f7f6f5f4f3f2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ref_block_loader.md
REF_BLOCK_LOADER -- requirements
Module: ref_block_loader

Interface
REQ-001 SHALL have parameter PIX_W, default 8, meaning bits per luma sample.
REQ-002 SHALL have parameter BLK_DIM, default 15, meaning samples per row and rows per block (8 + 7 filter taps).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port pix_in  input  PIX_W  meaning the raster-order sample stream.
REQ-006 SHALL have port pix_valid  input  1  meaning pix_in carries a sample.
REQ-007 SHALL have port pix_ready  output  1  meaning the loader accepts the sample this cycle.
REQ-008 SHALL have port next_row  input  8  meaning the row index requested by subpixel_interpolation.
REQ-009 SHALL have port in_row  output  PIX_W*BLK_DIM (120)  meaning the requested row of the read bank.
REQ-010 SHALL have port blk_valid  output  1  meaning the read bank holds a complete block.
REQ-011 SHALL have port blk_done  input  1  meaning a single-cycle pulse from the consumer releasing the read bank.
REQ-012 SHALL have port rd_bank  output  1  meaning the index of the bank currently served (debug).

Function
REQ-013 SHALL hold two banks of BLK_DIM row registers, each row PIX_W*BLK_DIM bits wide.
REQ-014 SHALL transfer a sample only on the cycle where pix_valid and pix_ready are both 1.
REQ-015 SHALL write the sample at column c into bits [PIX_W*c+PIX_W-1 : PIX_W*c] of the current row, with column 0 at the LSBs.
REQ-016 SHALL use a column counter 0..BLK_DIM-1 that wraps to 0 and advances the row counter 0..BLK_DIM-1.
REQ-017 SHALL, on the transfer of sample (row 14, col 14), mark the write bank FULL, toggle the write-bank pointer and clear both counters.
REQ-018 SHALL track the per-bank states EMPTY, FILLING and FULL; a bank is FILLING from its first accepted sample until its last.
REQ-019 SHALL drive pix_ready = 1 only while the write bank is EMPTY or FILLING.
REQ-020 SHALL drive pix_ready combinationally from registered state only, never from pix_valid.
REQ-021 SHALL drive blk_valid = 1 while the bank selected by rd_bank is FULL.
REQ-022 SHALL drive in_row combinationally as row[next_row] of the read bank.
REQ-023 SHALL drive in_row to all zeros when next_row >= BLK_DIM or blk_valid = 0.
REQ-024 SHALL, on blk_done while blk_valid = 1, set the read bank to EMPTY and toggle rd_bank on the next edge.
REQ-025 SHALL ignore blk_done while blk_valid = 0.
REQ-026 SHALL apply both events when blk_done and the final sample of the other bank occur in the same cycle, so that the new rd_bank is immediately FULL and blk_valid stays 1.
REQ-027 SHALL, when blk_done frees the bank that the loader is stalled on, raise pix_ready on the following cycle.
REQ-028 SHALL not modify row contents on release; stale data SHALL be overwritten by the next fill.

Reset
REQ-029 SHALL, on rst, set both banks to EMPTY, both pointers to 0, both counters to 0, blk_valid = 0 and pix_ready = 1 on the next cycle.
REQ-030 SHALL give rst priority over all other inputs, including mid-fill and mid-serve, discarding any partial block.
REQ-031 SHALL leave the row storage without a reset (data only); in_row SHALL be 0 after reset by REQ-023.

Structure
REQ-032 SHALL take PIX_W, BLK_DIM and the bank-state enumeration (EMPTY, FILLING, FULL) from the shared package hevc_interp_pkg.
REQ-033 SHALL instantiate one sub-module, ref_row_bank, per bank; it holds the row storage with a sample-write port and a row-read port.
REQ-034 SHALL be 120-400 lines of RTL excluding the package.

Verification
REQ-035 SHALL cover a fill of 225 samples 0x00..0xE0 -> blk_valid rises one cycle after the last transfer; next_row = 1 gives in_row = 0x1d..0x0f (MSB..LSB).
REQ-036 SHALL cover filling two blocks with no blk_done -> pix_ready = 0 after the 450th transfer and further pix_valid is not accepted.
REQ-037 SHALL cover a blk_done pulse while stalled -> rd_bank toggles, the second block is served, and pix_ready = 1 the next cycle.
REQ-038 SHALL cover blk_done coinciding with the last sample of bank 1 -> blk_valid stays 1 continuously and rd_bank = 1.
REQ-039 SHALL cover next_row = 15 and next_row = 0xFF with a block present -> in_row = 0.
REQ-040 SHALL cover rst asserted after 100 samples -> the next 225 samples form a clean block in bank 0, and blk_done with no valid block has no effect.
